// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART types and defaults (receiver, transmitter, baud generator)
package uart_pkg;

    localparam int UART_DATA_BITS   = 8;
    localparam int UART_SAMPLE_RATE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_IDLE
    } rx_state_t;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - received-word interface from uart_rx to the command parser
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] data;
    logic                 data_valid;
    logic                 framing_error;
    logic                 parity_error;

    modport master (output data, output data_valid, output framing_error, output parity_error);
    modport slave  (input  data, input  data_valid, input  framing_error, input  parity_error);
endinterface

// File: rtl/uart_sync.sv
// rtl/uart_sync.sv - multi-flop synchroniser for an async line that idles high
module uart_sync #(
    parameter int STAGES = 2
) (
    input  logic clock,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            chain <= '1;
        end else begin
            chain <= {chain[STAGES-2:0], d};
        end
    end

    assign q = chain[STAGES-1];
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - UART receiver, LSB first, stop-bit framing check; optional even parity via UART_RX_PARITY_EN
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = UART_DATA_BITS,
    parameter int SAMPLE_RATE = UART_SAMPLE_RATE,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx,
    input  logic        tick,
    output logic        start_rx,
    uart_rx_if.master   rx_word
);
    localparam int TW = $clog2(SAMPLE_RATE);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [TW-1:0] HALF_M1  = TW'(SAMPLE_RATE / 2 - 1);
    localparam logic [TW-1:0] FULL_M1  = TW'(SAMPLE_RATE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    rx_state_t             state_q, state_d;
    logic [TW-1:0]         tick_cnt_q, tick_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0]  shift_q, shift_d, data_q, data_d;
    logic                  rx_s, rx_prev_q;
    logic                  start_rx_q, start_rx_d;
    logic                  valid_q, valid_d, ferr_q, ferr_d, perr_q, perr_d;
    logic                  bit_end;
`ifdef UART_RX_PARITY_EN
    logic                  par_q, par_d;
`endif

    uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    assign bit_end = tick && (tick_cnt_q == FULL_M1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            data_q     <= '0;
            rx_prev_q  <= 1'b1;
            start_rx_q <= 1'b0;
            valid_q    <= 1'b0;
            ferr_q     <= 1'b0;
            perr_q     <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            data_q     <= data_d;
            rx_prev_q  <= rx_s;
            start_rx_q <= start_rx_d;
            valid_q    <= valid_d;
            ferr_q     <= ferr_d;
            perr_q     <= perr_d;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        data_d     = data_q;
        start_rx_d = 1'b0;
        valid_d    = 1'b0;
        ferr_d     = 1'b0;
        perr_d     = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d      = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (rx_prev_q && !rx_s) begin
                    start_rx_d = 1'b1;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = START;
                end
            end
            START: begin
                // Mid-start-bit re-check rejects short line glitches
                if (tick) begin
                    if (tick_cnt_q == HALF_M1) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shift_d    = {rx_s, shift_q[DATA_BITS-1:1]};
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                        state_d   = PARITY;
`else
                        state_d   = STOP;
`endif
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    par_d      = rx_s;
                    state_d    = STOP;
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    tick_cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                        perr_d  = (^shift_q) != par_q;
`endif
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_IDLE;
                    end
                end else if (tick) begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Held-low line (break) must release before a new start edge counts
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d    = IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase
    end

    assign start_rx              = start_rx_q;
    assign rx_word.data          = data_q;
    assign rx_word.data_valid    = valid_q;
    assign rx_word.framing_error = ferr_q;
    assign rx_word.parity_error  = perr_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed and random frame checks for uart_rx; parity cases under UART_RX_PARITY_EN
module tb_uart_rx;
    localparam int DIV      = 4;
    localparam int SR       = 16;
    localparam int BIT_CLKS = SR * DIV;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic tick;
    logic start_rx;
    int   gen_cnt;

    uart_rx_if #(.DATA_BITS(8)) u_if ();

    uart_rx #(.DATA_BITS(8), .SAMPLE_RATE(SR), .SYNC_STAGES(2)) dut (
        .clock    (clock),
        .reset_n  (reset_n),
        .rx       (rx),
        .tick     (tick),
        .start_rx (start_rx),
        .rx_word  (u_if)
    );

    always #5 clock = ~clock;

    // Baud generator stand-in: strobe every DIV clocks, re-phased by start_rx
    always @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          gen_cnt <= 0;
        else if (start_rx || gen_cnt == DIV-1) gen_cnt <= 0;
        else                                   gen_cnt <= gen_cnt + 1;
    end
    assign tick = (gen_cnt == DIV-1);

    int         n_valid = 0, n_ferr = 0, n_perr = 0, n_start = 0, n_clash = 0;
    logic [7:0] obs_q[$];

    always @(negedge clock) begin
        if (u_if.data_valid) begin
            obs_q.push_back(u_if.data);
            n_valid++;
        end
        if (u_if.framing_error) n_ferr++;
        if (u_if.parity_error) n_perr++;
        if (start_rx) n_start++;
        if (u_if.framing_error && u_if.data_valid) n_clash++;
    end

    int         compared = 0, mismatched = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good;
    int         v0, f0, p0, s0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx = b;
        clks(BIT_CLKS);
    endtask

    task automatic send_body(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    // Reference model: a frame with a high stop bit delivers its byte unchanged
    task automatic send_frame(input logic [7:0] d, input logic stop_bit);
        send_body(d);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_bit);
        if (stop_bit) begin
            exp_q.push_back(d);
            last_good = d;
        end
    endtask

    task automatic snap();
        v0 = n_valid; f0 = n_ferr; p0 = n_perr; s0 = n_start;
    endtask

    initial begin
        last_good = 8'h00;
        clks(4);
        chk("reset_data", 32'(u_if.data), 32'h0);
        chk("reset_valid", 32'(u_if.data_valid), 32'h0);
        chk("reset_ferr", 32'(u_if.framing_error), 32'h0);
        chk("reset_perr", 32'(u_if.parity_error), 32'h0);
        chk("reset_start_rx", 32'(start_rx), 32'h0);
        reset_n = 1'b1;
        clks(20);

        snap();
        send_frame(8'hA5, 1'b1);
        clks(10);
        chk("a5_valid_count", 32'(n_valid - v0), 32'd1);
        chk("a5_data", 32'(u_if.data), 32'hA5);
        chk("a5_ferr", 32'(n_ferr - f0), 32'd0);
        chk("a5_perr", 32'(n_perr - p0), 32'd0);
        chk("a5_start_rx", 32'(n_start - s0), 32'd1);

        snap();
        rx = 1'b0;
        clks(SR / 4 * DIV);
        rx = 1'b1;
        clks(2 * BIT_CLKS);
        chk("glitch_start_rx", 32'(n_start - s0), 32'd1);
        chk("glitch_valid", 32'(n_valid - v0), 32'd0);
        chk("glitch_ferr", 32'(n_ferr - f0), 32'd0);

        snap();
        send_frame(8'h3C, 1'b0);
        clks(3 * BIT_CLKS);
        chk("break_ferr", 32'(n_ferr - f0), 32'd1);
        chk("break_valid", 32'(n_valid - v0), 32'd0);
        chk("break_data_held", 32'(u_if.data), 32'(last_good));
        chk("break_no_start", 32'(n_start - s0), 32'd1);
        rx = 1'b1;
        clks(2 * BIT_CLKS);
        snap();
        send_frame(8'h11, 1'b1);
        clks(10);
        chk("after_break_valid", 32'(n_valid - v0), 32'd1);
        chk("after_break_data", 32'(u_if.data), 32'h11);

        snap();
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        clks(10);
        chk("b2b_valid_count", 32'(n_valid - v0), 32'd2);
        chk("b2b_first", 32'(obs_q[obs_q.size()-2]), 32'h00);
        chk("b2b_second", 32'(obs_q[obs_q.size()-1]), 32'hFF);

        obs_q.delete();
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1);
            clks($urandom_range(0, 20));
        end
        clks(10);
        chk("rand_count", 32'(obs_q.size()), 32'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
            chk($sformatf("rand_word_%0d", k), 32'(obs_q[k]), 32'(exp_q[k]));

        snap();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(8'h5A >> i);
        clks(BIT_CLKS / 3);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_data", 32'(u_if.data), 32'h0);
        chk("rst_valid", 32'(u_if.data_valid), 32'h0);
        chk("rst_ferr", 32'(u_if.framing_error), 32'h0);
        chk("rst_start_rx", 32'(start_rx), 32'h0);
        rx = 1'b1;
        clks(3);
        reset_n = 1'b1;
        clks(2 * BIT_CLKS);
        chk("rst_no_valid", 32'(n_valid - v0), 32'd0);
        snap();
        send_frame(8'h81, 1'b1);
        clks(10);
        chk("post_rst_valid", 32'(n_valid - v0), 32'd1);
        chk("post_rst_data", 32'(u_if.data), 32'h81);
        chk("post_rst_ferr", 32'(n_ferr - f0), 32'd0);

`ifdef UART_RX_PARITY_EN
        snap();
        send_body(8'h01);
        send_bit(1'b0);
        send_bit(1'b1);
        clks(10);
        chk("par_bad_valid", 32'(n_valid - v0), 32'd1);
        chk("par_bad_perr", 32'(n_perr - p0), 32'd1);
        chk("par_bad_data", 32'(u_if.data), 32'h01);
        snap();
        send_body(8'h01);
        send_bit(1'b1);
        send_bit(1'b1);
        clks(10);
        chk("par_good_valid", 32'(n_valid - v0), 32'd1);
        chk("par_good_perr", 32'(n_perr - p0), 32'd0);
`else
        chk("perr_tied_low", 32'(n_perr), 32'd0);
`endif
        chk("valid_ferr_exclusive", 32'(n_clash), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
